bcd_display_scanner: RTL
========================

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000: clock cycles each digit is driven; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port load, input, 1 bit: a high level on a rising clk edge captures value.
REQ-005 SHALL have port value, input, 16 bits: four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 SHALL have port pending, output, 1 bit: a captured value is waiting for the next frame boundary.
REQ-007 SHALL have port digit, output, 4 bits: BCD nibble for the currently enabled digit; feeds the 7-segment decoder.
REQ-008 SHALL have port anode, output, 4 bits: active-low digit enables, exactly one bit low at all times.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-010 SHALL keep a prescale counter cnt (0..PRESCALE-1), incrementing every cycle and wrapping to 0 after PRESCALE-1.
REQ-011 SHALL advance the digit index idx (0..3) by one when cnt wraps, with idx 3 wrapping to 0.
REQ-012 SHALL define the frame boundary as the cycle where cnt==PRESCALE-1 and idx==3.
REQ-013 SHALL register all outputs, so that anode and digit reflect the idx value in effect after each clock edge.
REQ-014 SHALL drive anode low only on bit idx (idx 0 gives 4'b1110, idx 3 gives 4'b0111).
REQ-015 SHALL drive digit with nibble idx of the display register.
REQ-016 SHALL capture value into a pending register when load is high and set pending; on multiple loads before a boundary, the last one wins.
REQ-017 SHALL, at a frame boundary with pending set, copy the pending register into the display register and clear pending.
REQ-018 SHALL, when load is high on the boundary cycle, move that cycle's value directly into the display register and leave pending clear.
REQ-019 SHALL never change the display register other than at a frame boundary, so no frame mixes two values.
REQ-020 SHALL pass non-BCD nibbles (A-F) unmodified on digit.
REQ-021 SHALL assert frame_done for exactly the one cycle following each frame boundary edge.

Reset
REQ-022 SHALL, while reset is high, immediately force cnt=0, idx=0, display=0, the pending register=0, pending=0, anode=4'b1110, digit=4'h0 and frame_done=0.
REQ-023 SHALL discard any load in progress during reset, including one on the same edge as reset deassertion.
REQ-024 SHALL begin counting on the first rising edge after reset deasserts, with digit 0 shown for a full PRESCALE cycles.

Configuration
REQ-025 SHALL, with macro LEADING_ZERO_BLANK_EN defined, output digit=4'hF for every zero nibble above the most significant nonzero nibble; digit 0 is never blanked.
REQ-026 SHALL, with LEADING_ZERO_BLANK_EN undefined, output all nibbles unmodified; anode scanning is identical in both builds.

Verification (PRESCALE=4)
REQ-027 SHALL cover: reset pulsed high mid-frame -> outputs at reset values immediately; after release, anode sequence 1110 x4, 1101 x4, 1011 x4, 0111 x4 cycles, then repeating.
REQ-028 SHALL cover: load 16'h1234 at cycle 2 after reset -> pending=1 until boundary; next frame digit = 4,3,2,1 with anode 1110,1101,1011,0111; frame_done pulses every 16 cycles.
REQ-029 SHALL cover: loads of 16'h1111 then 16'h9876 within one frame -> next frame shows only 6,7,8,9.
REQ-030 SHALL cover: load 16'h5555 exactly on a boundary cycle -> next frame shows 5,5,5,5; pending never asserts.
REQ-031 SHALL cover: value 16'h00A7 -> digit 7, A, 0, 0 without LEADING_ZERO_BLANK_EN; 7, A, F, F with it defined.
REQ-032 SHALL cover: value 16'h0000 with LEADING_ZERO_BLANK_EN defined -> digit F, F, F, 0 across indices 3..0.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexes a 4-digit BCD value onto one shared
//   7-segment decoder, driving one active-low anode per digit for PRESCALE cycles.
// Latency: outputs registered; a load becomes visible at the next frame boundary.
// Backpressure: none; load is accepted every cycle, and the last load before a
//   boundary wins.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-high
//   load       - capture value on this rising edge
//   value      - four BCD nibbles, [3:0] = digit 0 (rightmost)
//   pending    - a captured value is waiting for the next frame boundary
//   digit      - nibble for the currently enabled digit
//   anode      - active-low digit enables, exactly one bit low
//   frame_done - one-cycle pulse after each frame boundary edge
//
// Build option: define LEADING_ZERO_BLANK_EN to replace leading zero nibbles
//   (above the most significant nonzero nibble, never digit 0) with 4'hF.

module bcd_display_scanner #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    output logic        pending,
    output logic [3:0]  digit,
    output logic [3:0]  anode,
    output logic        frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_disp;
    logic [15:0]   r_pend_val;
    logic          r_pending;
    logic [3:0]    r_digit;
    logic [3:0]    r_anode;
    logic          r_frame_done;

    logic          w_cnt_wrap;
    logic          w_boundary;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_idx_nxt;
    logic [15:0]   w_disp_nxt;
    logic [3:0]    w_nib_nxt;
    logic [3:0]    w_digit_nxt;
    logic [3:0]    w_anode_nxt;

    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_boundary = w_cnt_wrap && (r_idx == 2'd3);
    assign w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + CW'(1);
    assign w_idx_nxt  = w_cnt_wrap ? r_idx + 2'd1 : r_idx;

    // The display register only moves on a boundary, so a frame never mixes
    // two values. A load on the boundary itself is newer than anything
    // pending and goes straight to the display.
    always_comb begin
        w_disp_nxt = r_disp;
        if (w_boundary) begin
            if (load)
                w_disp_nxt = value;
            else if (r_pending)
                w_disp_nxt = r_pend_val;
        end
    end

    // Outputs are computed from next-state values so that the registered
    // digit/anode match the index in effect after the edge.
    always_comb begin
        case (w_idx_nxt)
            2'd0:    w_nib_nxt = w_disp_nxt[3:0];
            2'd1:    w_nib_nxt = w_disp_nxt[7:4];
            2'd2:    w_nib_nxt = w_disp_nxt[11:8];
            default: w_nib_nxt = w_disp_nxt[15:12];
        endcase
    end

    always_comb begin
        case (w_idx_nxt)
            2'd0:    w_anode_nxt = 4'b1110;
            2'd1:    w_anode_nxt = 4'b1101;
            2'd2:    w_anode_nxt = 4'b1011;
            default: w_anode_nxt = 4'b0111;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lead_zero;

    // A nibble is a leading zero when it and every nibble above it are zero.
    // Digit 0 is always shown so an all-zero value still displays "0".
    always_comb begin
        w_lead_zero = 1'b0;
        case (w_idx_nxt)
            2'd3:    w_lead_zero = (w_disp_nxt[15:12] == 4'h0);
            2'd2:    w_lead_zero = (w_disp_nxt[15:8]  == 8'h00);
            2'd1:    w_lead_zero = (w_disp_nxt[15:4]  == 12'h000);
            default: w_lead_zero = 1'b0;
        endcase
        w_digit_nxt = w_lead_zero ? 4'hF : w_nib_nxt;
    end
`else
    assign w_digit_nxt = w_nib_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_disp       <= 16'h0000;
            r_pend_val   <= 16'h0000;
            r_pending    <= 1'b0;
            r_digit      <= 4'h0;
            r_anode      <= 4'b1110;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_disp       <= w_disp_nxt;
            r_digit      <= w_digit_nxt;
            r_anode      <= w_anode_nxt;
            r_frame_done <= w_boundary;
            if (w_boundary) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_pend_val <= value;
                r_pending  <= 1'b1;
            end
        end
    end

    assign pending    = r_pending;
    assign digit      = r_digit;
    assign anode      = r_anode;
    assign frame_done = r_frame_done;

endmodule
